axil_req_master: RTL and testbench
==================================

// Module: axil_req_master
// PURPOSE
//  Single-outstanding AXI-Lite master sitting directly upstream of the AXI-Lite register/memory slave.
//  Accepts one MMIO request (read or write) from the PCIe request decoder on a valid/ready port.
//  Issues the request as an AXI-Lite transaction and returns one completion (data/status/tag) downstream.
//  A watchdog returns an error completion if the slave never responds, so host reads cannot hang.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles from request acceptance to forced error completion; 0 disables the watchdog
//  TAG_W           8     width of the opaque request tag echoed in the completion
// PORTS
//  clk            in   1      single clock; all logic is synchronous to its rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  req_valid      in   1      request present
//  req_ready      out  1      request accepted when req_valid & req_ready
//  req_we         in   1      1 = write, 0 = read
//  req_addr       in   32     byte address, passed to the AXI address channel unmodified
//  req_wdata      in   32     write data
//  req_wstrb      in   4      write byte strobes
//  req_tag        in   TAG_W  opaque tag
//  cpl_valid      out  1      completion present
//  cpl_ready      in   1      completion consumed when cpl_valid & cpl_ready
//  cpl_we         out  1      echo of req_we
//  cpl_rdata      out  32     read data; 0 for writes; 32'hFFFF_FFFF on error
//  cpl_err        out  1      1 = SLVERR/DECERR response or timeout
//  cpl_tag        out  TAG_W  echo of req_tag
//  m_axi_aw*/w*/b*/ar*/r*     standard AXI-Lite master: awaddr[31:0] awvalid awready, wdata[31:0] wstrb[3:0] wvalid
//                             wready, bresp[1:0] bvalid bready, araddr[31:0] arvalid arready, rdata[31:0] rresp[1:0]
//                             rvalid rready
// BEHAVIOUR
//  - Reset (asynchronous, immediate): state IDLE; all AXI valid/ready outputs 0; cpl_valid 0; req_ready 1 after
//    reset deassertion; all data outputs 0. A reset mid-transaction abandons the transaction with no completion.
//  - FSM states: IDLE -> WR | RD -> CPL -> IDLE | DRAIN -> IDLE. req_ready = (state == IDLE); requests are
//    registered on acceptance.
//  - WR: awvalid and wvalid rise one cycle after acceptance. Each channel is held until its own handshake;
//    the two channels complete independently in either order or in the same cycle. bready = 1 once both are
//    done. The bvalid & bready handshake moves the FSM to CPL.
//  - RD: arvalid rises one cycle after acceptance and is held until arready. rready = 1 after the AR handshake.
//    The rvalid & rready handshake captures rdata/rresp and moves the FSM to CPL.
//  - Latency: zero-wait slave -> cpl_valid asserts 3 cycles after the request handshake.
//  - cpl_err = resp[1]. EXOKAY is treated as OKAY. cpl_rdata is forced to all-ones when cpl_err = 1.
//  - CPL: cpl_valid is held with all fields stable until cpl_ready. A same-cycle new request is not accepted;
//    the next request is accepted in IDLE, 1 cycle after the completion handshake.
//  - Watchdog: counts cycles in WR/RD. At count == TIMEOUT_CYCLES the FSM enters CPL with cpl_err = 1 and sets
//    orphan = 1. AXI valids are never dropped before their handshake, and the AXI side keeps running in CPL.
//    A late response arriving while orphan = 1 is accepted and discarded.
//  - Exit from CPL: if orphan = 1 and the AXI transaction is still outstanding, go to DRAIN; otherwise go to IDLE.
//  - DRAIN: wait for the remaining handshakes (aw/w/b or ar/r), then go to IDLE and clear orphan.
//  - The watchdog counter saturates and never wraps. The counter is cleared on every entry to WR/RD.
// STRUCTURE
//  - axil_pkg: state enum (IDLE, WR, RD, CPL, DRAIN), AXI resp constants (OKAY=2'b00, EXOKAY=2'b01,
//    SLVERR=2'b10, DECERR=2'b11), ERR_RDATA = 32'hFFFF_FFFF.
//  - One sub-module: axil_timeout_ctr, a clear/enable/saturating counter with an expired flag and a
//    TIMEOUT_CYCLES parameter. Width is $clog2(TIMEOUT_CYCLES+1). When TIMEOUT_CYCLES = 0, expired is tied to 0.
//  - Everything else (FSM, channel-done flags, orphan flag, completion registers) lives in this module.
// TESTING
//  1. Write addr 0x10, data 0xCAFEBABE, strb 0xF, tag 0x5A; zero-wait slave -> AW/W beats carry those values,
//     cpl_valid 3 cycles after request, cpl_err 0, cpl_tag 0x5A.
//  2. Read addr 0x10 after test 1 -> cpl_rdata 0xCAFEBABE, cpl_err 0, cpl_we 0.
//  3. Slave accepts W 4 cycles before AW; bvalid is delayed 5 cycles -> wvalid drops after its handshake;
//     bready only after both; a single completion.
//  4. Slave returns rresp = 2'b10 -> cpl_err 1, cpl_rdata 0xFFFFFFFF.
//  5. TIMEOUT_CYCLES = 16, slave never asserts arready -> error completion at cycle 16. Then arready/rvalid are
//     given -> response is discarded, FSM passes through DRAIN, and the next request completes normally.
//  6. Assert rst_n low mid-WR with cpl_ready held 0 -> awvalid, wvalid and cpl_valid fall asynchronously;
//     req_ready = 1 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared FSM states, AXI response codes and error data for the AXI-Lite request master.
package axil_pkg;
    typedef enum logic [2:0] {IDLE, WR, RD, CPL, DRAIN} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [31:0] ERR_RDATA  = 32'hFFFF_FFFF;
endpackage

// File: rtl/axil_if.sv
// axil_if: AXI-Lite bus bundle with master and slave views.
interface axil_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_timeout_ctr.sv
// axil_timeout_ctr: clearable saturating cycle counter; expired marks the TIMEOUT_CYCLES-th enabled cycle.
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused;
        assign unused  = ^{clk, rst_n, clr, en};
        assign expired = 1'b0;
    end else begin : g_on
        localparam int W = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
        localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
        logic [W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (clr) cnt <= '0;
            else if (en && cnt != MAX) cnt <= cnt + 1'b1;
        end
        // cnt holds completed cycles, so cnt == LAST is the final allowed cycle
        assign expired = en && cnt >= LAST;
    end
endmodule

// File: rtl/axil_req_master.sv
// axil_req_master: single-outstanding MMIO request to AXI-Lite master with watchdog-forced error completions.
module axil_req_master
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TAG_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    input  logic [TAG_W-1:0] req_tag,
    output logic             cpl_valid,
    input  logic             cpl_ready,
    output logic             cpl_we,
    output logic [31:0]      cpl_rdata,
    output logic             cpl_err,
    output logic [TAG_W-1:0] cpl_tag,
    axil_if.master           m_axi
);
    state_t state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic aw_pend, w_pend, b_pend, ar_pend, r_pend, orphan, expired;
    logic accept, busy, aw_hs, w_hs, b_hs, ar_hs, r_hs, done, timeout, outstanding;
    logic [1:0] resp;

    assign req_ready   = state == IDLE;
    assign cpl_valid   = state == CPL;
    assign accept      = req_valid && req_ready;
    assign busy        = state == WR || state == RD;
    assign aw_hs       = m_axi.awvalid && m_axi.awready;
    assign w_hs        = m_axi.wvalid && m_axi.wready;
    assign b_hs        = m_axi.bvalid && m_axi.bready;
    assign ar_hs       = m_axi.arvalid && m_axi.arready;
    assign r_hs        = m_axi.rvalid && m_axi.rready;
    assign done        = state == WR ? b_hs : state == RD && r_hs;
    assign timeout     = busy && expired && !done;
    assign resp        = state == WR ? m_axi.bresp : m_axi.rresp;
    assign outstanding = aw_pend || w_pend || b_pend || ar_pend || r_pend;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.awvalid = aw_pend;
    assign m_axi.wvalid  = w_pend;
    assign m_axi.bready  = b_pend && !aw_pend && !w_pend;
    assign m_axi.arvalid = ar_pend;
    assign m_axi.rready  = r_pend && !ar_pend;

    axil_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (busy),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? (req_we ? WR : RD) : IDLE;
            WR, RD:  state_nxt = done || timeout ? CPL : state;
            CPL:     state_nxt = cpl_ready ? (orphan && outstanding ? DRAIN : IDLE) : CPL;
            DRAIN:   state_nxt = outstanding ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // Channel flags keep running in CPL/DRAIN so an abandoned transaction still finishes cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {aw_pend, w_pend, b_pend, ar_pend, r_pend} <= '0;
        end else if (accept) begin
            {aw_pend, w_pend, b_pend} <= {3{req_we}};
            {ar_pend, r_pend}         <= {2{!req_we}};
        end else begin
            aw_pend <= aw_pend && !aw_hs;
            w_pend  <= w_pend && !w_hs;
            b_pend  <= b_pend && !b_hs;
            ar_pend <= ar_pend && !ar_hs;
            r_pend  <= r_pend && !r_hs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cpl_we    <= 1'b0;
            cpl_tag   <= '0;
            cpl_err   <= 1'b0;
            cpl_rdata <= '0;
            orphan    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                cpl_we  <= req_we;
                cpl_tag <= req_tag;
            end
            if (done) begin
                cpl_err   <= resp[1];
                cpl_rdata <= resp[1] ? ERR_RDATA : (state == RD ? m_axi.rdata : '0);
            end else if (timeout) begin
                cpl_err   <= 1'b1;
                cpl_rdata <= ERR_RDATA;
            end
            orphan <= state_nxt == IDLE ? 1'b0 : (timeout || orphan);
        end
    end
endmodule

// File: tb/tb_axil_req_master.sv
// tb_axil_req_master: directed scenarios against a small AXI-Lite slave model with tunable stalls.
module tb_axil_req_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, cpl_ready = 1'b0;
    logic        req_ready, cpl_valid, cpl_we, cpl_err;
    logic [31:0] req_addr = '0, req_wdata = '0, cpl_rdata;
    logic [3:0]  req_wstrb = '0;
    logic [7:0]  req_tag = '0, cpl_tag;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    axil_if bus ();

    axil_req_master #(.TIMEOUT_CYCLES(16), .TAG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_tag   (req_tag),
        .cpl_valid (cpl_valid),
        .cpl_ready (cpl_ready),
        .cpl_we    (cpl_we),
        .cpl_rdata (cpl_rdata),
        .cpl_err   (cpl_err),
        .cpl_tag   (cpl_tag),
        .m_axi     (bus)
    );

    // Slave model: ready stalls per channel, delayed B, gated AR, 16-word memory
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    logic ar_en = 1'b1;
    logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    int aw_cnt, w_cnt, b_wait, n_b, n_r;
    logic b_arm, aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0] w_s;
    logic [31:0] mem [16];
    logic aw_hs, w_hs, both_done;
    logic [31:0] wr_a, wr_d;
    logic [3:0] wr_s;

    assign bus.awready = bus.awvalid && aw_cnt >= aw_dly;
    assign bus.wready  = bus.wvalid && w_cnt >= w_dly;
    assign bus.arready = bus.arvalid && ar_en;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign both_done = (aw_got || aw_hs) && (w_got || w_hs) && (aw_hs || w_hs);
    assign wr_a = aw_hs ? bus.awaddr : aw_a;
    assign wr_d = w_hs ? bus.wdata : w_d;
    assign wr_s = w_hs ? bus.wstrb : w_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0; b_wait <= 0; b_arm <= 1'b0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
            n_b <= 0; n_r <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= bus.awvalid && !bus.awready ? aw_cnt + 1 : 0;
            w_cnt  <= bus.wvalid && !bus.wready ? w_cnt + 1 : 0;
            if (aw_hs) aw_a <= bus.awaddr;
            if (w_hs) begin
                w_d <= bus.wdata;
                w_s <= bus.wstrb;
            end
            if (both_done) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                for (int i = 0; i < 4; i++)
                    if (wr_s[i]) mem[wr_a[5:2]][8*i +: 8] <= wr_d[8*i +: 8];
                if (b_dly == 0) begin
                    bus.bvalid <= 1'b1;
                    bus.bresp  <= b_resp_cfg;
                end else begin
                    b_arm  <= 1'b1;
                    b_wait <= b_dly;
                end
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
            if (b_arm) begin
                if (b_wait == 1) begin
                    b_arm      <= 1'b0;
                    bus.bvalid <= 1'b1;
                    bus.bresp  <= b_resp_cfg;
                end else b_wait <= b_wait - 1;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                n_b <= n_b + 1;
            end
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem[bus.araddr[5:2]];
                bus.rresp  <= r_resp_cfg;
            end
            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                n_r <= n_r + 1;
            end
        end
    end

    task automatic send_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [7:0] t);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_tag = t;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_cpl(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpl_valid && n < 100);
    endtask

    task automatic take_cpl;
        cpl_ready = 1'b1;
        @(posedge clk);
        #1 cpl_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
        checks++;
        if ({cpl_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 6'b0)
            $display("FAIL reset_valids got %b want 000000",
                     {cpl_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        else passed++;
        checks++; if (cpl_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", cpl_rdata); else passed++;
    endtask

    task automatic test_write_basic;
        int n;
        send_req(1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 8'h5A);
        wait_cpl(n);
        checks++; if (n !== 3) $display("FAIL wr_latency got %0d want 3", n); else passed++;
        checks++;
        if ({cpl_valid, cpl_err, cpl_we, cpl_tag} !== {1'b1, 1'b0, 1'b1, 8'h5A})
            $display("FAIL wr_cpl got v%b e%b we%b tag%h want v1 e0 we1 tag5a", cpl_valid, cpl_err, cpl_we, cpl_tag);
        else passed++;
        checks++; if (cpl_rdata !== 32'h0) $display("FAIL wr_rdata got %h want 0", cpl_rdata); else passed++;
        checks++;
        if ({aw_a, w_d, w_s} !== {32'h10, 32'hCAFEBABE, 4'hF})
            $display("FAIL wr_beats got %h %h %h want 10 cafebabe f", aw_a, w_d, w_s);
        else passed++;
        take_cpl();
        @(negedge clk);
        checks++;
        if ({req_ready, cpl_valid} !== 2'b10)
            $display("FAIL wr_after_cpl got ready%b valid%b want ready1 valid0", req_ready, cpl_valid);
        else passed++;
    endtask

    task automatic test_read_basic;
        int n;
        send_req(1'b0, 32'h10, 32'h0, 4'h0, 8'hA5);
        wait_cpl(n);
        checks++; if (n !== 3) $display("FAIL rd_latency got %0d want 3", n); else passed++;
        checks++;
        if ({cpl_rdata, cpl_err, cpl_we, cpl_tag} !== {32'hCAFEBABE, 1'b0, 1'b0, 8'hA5})
            $display("FAIL rd_cpl got %h e%b we%b tag%h want cafebabe e0 we0 taga5", cpl_rdata, cpl_err, cpl_we, cpl_tag);
        else passed++;
        take_cpl();
    endtask

    task automatic test_w_before_aw;
        int n, aw_n, w_n, viol, nb0, extra;
        logic w_seen;
        aw_dly = 4; b_dly = 5;
        nb0 = n_b; aw_n = 0; w_n = 0; viol = 0; w_seen = 1'b0; n = 0;
        send_req(1'b1, 32'h20, 32'h12345678, 4'b0011, 8'h77);
        do begin
            @(negedge clk);
            n++;
            if (w_seen && bus.wvalid) viol++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) viol++;
            if (bus.wvalid && bus.wready) begin w_seen = 1'b1; w_n = n; end
            if (bus.awvalid && bus.awready) aw_n = n;
        end while (!cpl_valid && n < 100);
        checks++;
        if (aw_n - w_n !== 4 || w_n !== 1) $display("FAIL ooo_order got w@%0d aw@%0d want w@1 aw@5", w_n, aw_n);
        else passed++;
        checks++; if (viol !== 0) $display("FAIL ooo_protocol got %0d violations want 0", viol); else passed++;
        checks++; if (n !== 12) $display("FAIL ooo_latency got %0d want 12", n); else passed++;
        checks++;
        if ({cpl_err, cpl_tag} !== {1'b0, 8'h77}) $display("FAIL ooo_cpl got e%b tag%h want e0 tag77", cpl_err, cpl_tag);
        else passed++;
        take_cpl();
        extra = 0;
        repeat (4) begin @(negedge clk); if (cpl_valid) extra++; end
        checks++; if (extra !== 0 || n_b - nb0 !== 1) $display("FAIL ooo_single got extra%0d b%0d want extra0 b1", extra, n_b - nb0);
        else passed++;
        aw_dly = 0; b_dly = 0;
    endtask

    task automatic test_err_resp;
        int n;
        r_resp_cfg = 2'b10;
        send_req(1'b0, 32'h10, 32'h0, 4'h0, 8'h11);
        wait_cpl(n);
        checks++;
        if ({cpl_err, cpl_rdata} !== {1'b1, 32'hFFFFFFFF})
            $display("FAIL rd_slverr got e%b %h want e1 ffffffff", cpl_err, cpl_rdata);
        else passed++;
        take_cpl();
        r_resp_cfg = 2'b01;
        send_req(1'b0, 32'h10, 32'h0, 4'h0, 8'h12);
        wait_cpl(n);
        checks++;
        if ({cpl_err, cpl_rdata} !== {1'b0, 32'hCAFEBABE})
            $display("FAIL rd_exokay got e%b %h want e0 cafebabe", cpl_err, cpl_rdata);
        else passed++;
        take_cpl();
        r_resp_cfg = 2'b00; b_resp_cfg = 2'b11;
        send_req(1'b1, 32'h30, 32'h0BAD0BAD, 4'hF, 8'h13);
        wait_cpl(n);
        checks++;
        if ({cpl_err, cpl_we, cpl_rdata} !== {1'b1, 1'b1, 32'hFFFFFFFF})
            $display("FAIL wr_decerr got e%b we%b %h want e1 we1 ffffffff", cpl_err, cpl_we, cpl_rdata);
        else passed++;
        take_cpl();
        b_resp_cfg = 2'b00;
    endtask

    task automatic test_timeout;
        int n, k, drain_cpl, nr0;
        ar_en = 1'b0;
        nr0 = n_r;
        send_req(1'b0, 32'h20, 32'h0, 4'h0, 8'h33);
        wait_cpl(n);
        checks++; if (n !== 17) $display("FAIL to_latency got %0d want 17", n); else passed++;
        checks++;
        if ({cpl_valid, cpl_err, cpl_rdata, cpl_tag} !== {1'b1, 1'b1, 32'hFFFFFFFF, 8'h33})
            $display("FAIL to_cpl got v%b e%b %h tag%h want v1 e1 ffffffff tag33", cpl_valid, cpl_err, cpl_rdata, cpl_tag);
        else passed++;
        @(negedge clk);
        checks++; if (bus.arvalid !== 1'b1) $display("FAIL to_arvalid_held got %b want 1", bus.arvalid); else passed++;
        take_cpl();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, cpl_valid} !== 2'b00) $display("FAIL to_drain got ready%b valid%b want 00", req_ready, cpl_valid);
        else passed++;
        ar_en = 1'b1;
        k = 0; drain_cpl = 0;
        do begin
            @(negedge clk);
            k++;
            if (cpl_valid) drain_cpl++;
        end while (!req_ready && k < 20);
        checks++;
        if ({req_ready, drain_cpl, n_r - nr0} !== {1'b1, 32'd0, 32'd1})
            $display("FAIL to_drain_exit got ready%b cpl%0d r%0d want ready1 cpl0 r1", req_ready, drain_cpl, n_r - nr0);
        else passed++;
        send_req(1'b0, 32'h20, 32'h0, 4'h0, 8'h44);
        wait_cpl(n);
        checks++;
        if ({n[7:0], cpl_err, cpl_rdata, cpl_tag} !== {8'd3, 1'b0, 32'h00005678, 8'h44})
            $display("FAIL to_next got n%0d e%b %h tag%h want n3 e0 00005678 tag44", n, cpl_err, cpl_rdata, cpl_tag);
        else passed++;
        take_cpl();
    endtask

    task automatic test_reset_mid_wr;
        int extra;
        aw_dly = 40; w_dly = 40;
        send_req(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.awvalid, bus.wvalid} !== 2'b11) $display("FAIL rst_pre got aw%b w%b want 11", bus.awvalid, bus.wvalid);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.awvalid, bus.wvalid, cpl_valid} !== 3'b000)
            $display("FAIL rst_async got aw%b w%b cpl%b want 000", bus.awvalid, bus.wvalid, cpl_valid);
        else passed++;
        @(negedge clk);
        aw_dly = 0; w_dly = 0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, bus.awaddr, cpl_tag} !== {1'b1, 32'h0, 8'h0})
            $display("FAIL rst_release got ready%b addr%h tag%h want ready1 addr0 tag0", req_ready, bus.awaddr, cpl_tag);
        else passed++;
        extra = 0;
        repeat (5) begin @(negedge clk); if (cpl_valid || bus.awvalid) extra++; end
        checks++; if (extra !== 0) $display("FAIL rst_abandon got %0d stray cycles want 0", extra); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_w_before_aw();
        test_err_resp();
        test_timeout();
        test_reset_mid_wr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end
endmodule
